// File: rtl/traffic_pkg.sv
// Shared types and the LFSR pattern used by both the generator and checker of each channel.
// Pattern: 32-bit Fibonacci LFSR x^32+x^22+x^2+x+1, shifted left with feedback into bit 0.
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Taps at state bits 31, 21, 1, 0.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_POLY)};
  endfunction

endpackage

// File: rtl/stream_traffic_gen_chk_if.sv
// Per-channel valid/ready bundle: outbound tx stream and returned rx stream.
// master = traffic generator/checker side, slave = link under test.
interface stream_traffic_gen_chk_if #(
  parameter int NUM_CHANNELS = 1,
  parameter int DATA_WIDTH   = 32
);
  logic [NUM_CHANNELS-1:0]            tx_valid;
  logic [NUM_CHANNELS-1:0]            tx_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_data;
  logic [NUM_CHANNELS-1:0]            rx_valid;
  logic [NUM_CHANNELS-1:0]            rx_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/traffic_channel.sv
// One channel: LFSR word generator on tx, regenerating checker with saturating error count on rx.
// tx word is the current LFSR state, so it stays stable while stalled; err_count updates one cycle after rx handshake.
module traffic_channel
  import traffic_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [31:0] SEED       = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic                  run,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_ready,
  output logic                  chan_done,
  output logic                  rx_hs,
  output logic                  err_zero,
  output logic [LEN_WIDTH-1:0]  err_count
);
  logic [31:0]          gen_lfsr;
  logic [31:0]          chk_lfsr;
  logic [LEN_WIDTH-1:0] tx_cnt;
  logic [LEN_WIDTH-1:0] rx_cnt;
  logic                 tx_hs;

  assign tx_valid = run && (tx_cnt < len);
  assign rx_ready = run && (rx_cnt < len);
  assign tx_hs    = tx_valid && tx_ready;
  assign rx_hs    = rx_valid && rx_ready;
  assign tx_data  = gen_lfsr[DATA_WIDTH-1:0];
  assign err_zero = (err_count == '0);

  // Includes this cycle's handshake so the FSM can leave RUN on the edge of the last word.
  assign chan_done = ((rx_cnt + LEN_WIDTH'(rx_hs)) == len);

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_lfsr  <= '0;
      chk_lfsr  <= '0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      err_count <= '0;
    end else if (launch) begin
      gen_lfsr  <= SEED;
      chk_lfsr  <= SEED;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      err_count <= '0;
    end else begin
      if (tx_hs) begin
        gen_lfsr <= lfsr_next(gen_lfsr);
        tx_cnt   <= tx_cnt + LEN_WIDTH'(1);
      end
      if (rx_hs) begin
        chk_lfsr <= lfsr_next(chk_lfsr);
        rx_cnt   <= rx_cnt + LEN_WIDTH'(1);
        if ((rx_data != chk_lfsr[DATA_WIDTH-1:0]) && (err_count != '1))
          err_count <= err_count + LEN_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/stream_traffic_gen_chk.sv
// Multi-channel stream traffic generator/checker: run FSM, idle timeout, burst length latch and pass verdict.
// busy/tx_valid one cycle after start; done one cycle after the last rx word or after TIMEOUT_CYCLES idle RUN cycles.
module stream_traffic_gen_chk
  import traffic_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          NUM_CHANNELS   = 1,
  parameter int          LEN_WIDTH      = 16,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] SEED           = 32'hACE1_0001
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [LEN_WIDTH-1:0]              burst_len,
  stream_traffic_gen_chk_if.master          link,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic                              timeout,
  output logic [NUM_CHANNELS*LEN_WIDTH-1:0] err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                             state;
  logic [LEN_WIDTH-1:0]               len_q;
  logic [TW-1:0]                      idle_cnt;
  logic                               run;
  logic                               launch;
  logic [NUM_CHANNELS-1:0]            chan_done;
  logic [NUM_CHANNELS-1:0]            rx_hs;
  logic [NUM_CHANNELS-1:0]            err_zero;
  logic [NUM_CHANNELS-1:0]            tx_valid;
  logic [NUM_CHANNELS-1:0]            rx_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] tx_data;

  assign run           = (state == RUN);
  assign launch        = start && !run;
  assign link.tx_valid = tx_valid;
  assign link.tx_data  = tx_data;
  assign link.rx_ready = rx_ready;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    traffic_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH),
      .SEED       (SEED ^ 32'(c))
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .launch    (launch),
      .run       (run),
      .len       (len_q),
      .tx_valid  (tx_valid[c]),
      .tx_data   (tx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .tx_ready  (link.tx_ready[c]),
      .rx_valid  (link.rx_valid[c]),
      .rx_data   (link.rx_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rx_ready  (rx_ready[c]),
      .chan_done (chan_done[c]),
      .rx_hs     (rx_hs[c]),
      .err_zero  (err_zero[c]),
      .err_count (err_count[c*LEN_WIDTH +: LEN_WIDTH])
    );
  end

  // Completion is tested before the idle limit so a last word arriving at expiry still passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      idle_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            len_q    <= burst_len;
            idle_cnt <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            timeout  <= 1'b0;
          end
        end
        RUN: begin
          if (&chan_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (idle_cnt == TW'(TIMEOUT_CYCLES)) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (|rx_hs) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign pass = done && !timeout && (&err_zero);

endmodule

// File: tb/tb_stream_traffic_gen_chk.sv
// Scoreboard bench: stimulus queues expected tx words and run verdicts, a negedge monitor pops and compares.
// Link side modes: 0 loopback, 1 registered loopback with toggling tx_ready, 2 loopback with ch1 corruption, 3 no rx.
module tb_stream_traffic_gen_chk;
  localparam int DW  = 32;
  localparam int NC  = 2;
  localparam int LW  = 16;
  localparam int TMO = 8;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, pass, timeout;
  logic [NC*LW-1:0] err_count;

  stream_traffic_gen_chk_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) lnk ();

  stream_traffic_gen_chk #(
    .DATA_WIDTH     (DW),
    .NUM_CHANNELS   (NC),
    .LEN_WIDTH      (LW),
    .TIMEOUT_CYCLES (TMO),
    .SEED           (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .burst_len (burst_len),
    .link      (lnk.master),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            lat;
    logic          ps;
    logic          tmo;
    logic [NC*LW-1:0] errs;
  } res_t;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int mode = 0;
  int idx1 = 0;
  logic tog = 1'b0;
  logic [NC-1:0]    lb_v = '0;
  logic [NC*DW-1:0] lb_d = '0;
  res_t       res_q[$];
  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, expv);
    end
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    tog <= ~tog;
    if (start) idx1 <= 0;
    else if (lnk.rx_valid[1] && lnk.rx_ready[1]) idx1 <= idx1 + 1;
    for (int c = 0; c < NC; c++) begin
      if (mode != 1 || rst) lb_v[c] <= 1'b0;
      else if (lnk.tx_valid[c] && lnk.tx_ready[c]) begin
        lb_v[c] <= 1'b1;
        lb_d[c*DW +: DW] <= lnk.tx_data[c*DW +: DW];
      end else if (lnk.rx_ready[c]) lb_v[c] <= 1'b0;
    end
  end

  always_comb begin
    lnk.tx_ready = '1;
    lnk.rx_valid = lnk.tx_valid;
    lnk.rx_data  = lnk.tx_data;
    case (mode)
      1: begin
        lnk.tx_ready = {NC{tog}};
        lnk.rx_valid = lb_v;
        lnk.rx_data  = lb_d;
      end
      2: lnk.rx_data = lnk.tx_data ^ (((idx1 == 2) || (idx1 == 6)) ? 64'h1_0000_0000 : 64'h0);
      3: lnk.rx_valid = '0;
      default: ;
    endcase
  end

  // Monitor: tx words against the queued sequence, stall stability, and run verdict on rising done.
  logic          done_prev = 1'b0;
  logic [NC-1:0] stall_prev = '0;
  logic [DW-1:0] hold_d [NC];

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) begin
        logic [DW-1:0] cur;
        logic [DW-1:0] e;
        logic          have;
        cur  = lnk.tx_data[c*DW +: DW];
        have = 1'b0;
        e    = '0;
        if (stall_prev[c] && lnk.tx_valid[c])
          chk($sformatf("tx_hold_ch%0d", c), 64'(cur), 64'(hold_d[c]));
        if (lnk.tx_valid[c] && lnk.tx_ready[c]) begin
          if (c == 0) begin
            have = exp0.size() > 0;
            if (have) e = exp0.pop_front();
          end else begin
            have = exp1.size() > 0;
            if (have) e = exp1.pop_front();
          end
          if (have) chk($sformatf("tx_data_ch%0d", c), 64'(cur), 64'(e));
          else      chk($sformatf("tx_extra_ch%0d", c), 64'(lnk.tx_valid[c]), 64'd0);
        end
        stall_prev[c] = lnk.tx_valid[c] && !lnk.tx_ready[c];
        hold_d[c]     = cur;
      end
      if (done && !done_prev) begin
        if (res_q.size() == 0) chk("done_extra", 64'(done), 64'd0);
        else begin
          res_t r;
          r = res_q.pop_front();
          if (r.lat >= 0) chk("done_latency", 64'(cyc - start_cyc), 64'(r.lat));
          chk("pass", 64'(pass), 64'(r.ps));
          chk("timeout", 64'(timeout), 64'(r.tmo));
          chk("err_count", 64'(err_count), 64'(r.errs));
          chk("busy_at_done", 64'(busy), 64'd0);
        end
      end
      done_prev = done;
    end else begin
      stall_prev = '0;
      done_prev  = 1'b0;
    end
  end

  task automatic push_words(input int n);
    logic [31:0] s0, s1;
    s0 = SEED;
    s1 = SEED ^ 32'd1;
    for (int i = 0; i < n; i++) begin
      exp0.push_back(s0[DW-1:0]);
      exp1.push_back(s1[DW-1:0]);
      s0 = ref_step(s0);
      s1 = ref_step(s1);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the next posedge (first RUN cycle).
  task automatic launch(input int m, input int len, input bit with_res, input res_t r, input int words);
    mode      = m;
    burst_len = LW'(len);
    push_words(words);
    if (with_res) res_q.push_back(r);
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (res_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (res_q.size() != 0) begin
      chk("done_wait_timeout", 64'(res_q.size()), 64'd0);
      res_q.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_tx_valid"}, 64'(lnk.tx_valid), 64'd0);
    chk({tag, "_rx_ready"}, 64'(lnk.rx_ready), 64'd0);
    chk({tag, "_tx_data"}, lnk.tx_data, 64'd0);
    chk({tag, "_err_count"}, 64'(err_count), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Loopback, 16 words per channel.
    launch(0, 16, 1'b1, '{lat: 17, ps: 1'b1, tmo: 1'b0, errs: '0}, 16);
    @(negedge clk);
    chk("first_word_ch0", 64'(lnk.tx_data[31:0]), 64'hACE1_0001);
    chk("first_word_ch1", 64'(lnk.tx_data[63:32]), 64'hACE1_0000);
    chk("first_busy", 64'(busy), 64'd1);
    chk("first_tx_valid", 64'(lnk.tx_valid), 64'd3);
    @(negedge clk);
    chk("second_word_ch0", 64'(lnk.tx_data[31:0]), 64'h59C2_0003);
    chk("second_word_ch1", 64'(lnk.tx_data[63:32]), 64'h59C2_0000);
    wait_done(60);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("done_hold", 64'(done), 64'd1);
    chk("pass_hold", 64'(pass), 64'd1);

    // Backpressure through a registered loopback.
    launch(1, 16, 1'b1, '{lat: -1, ps: 1'b1, tmo: 1'b0, errs: '0}, 16);
    wait_done(150);

    // Corrupt bit 0 of the 3rd and 7th ch1 words.
    launch(2, 16, 1'b1, '{lat: 17, ps: 1'b0, tmo: 1'b0, errs: 32'h0002_0000}, 16);
    wait_done(60);

    // No returned data: 9 RUN cycles of tx, then timeout.
    launch(3, 16, 1'b1, '{lat: 10, ps: 1'b0, tmo: 1'b1, errs: '0}, 9);
    wait_done(60);

    // Zero length.
    launch(0, 0, 1'b1, '{lat: 2, ps: 1'b1, tmo: 1'b0, errs: '0}, 0);
    chk("zero_busy", 64'(busy), 64'd1);
    chk("zero_tx_valid", 64'(lnk.tx_valid), 64'd0);
    wait_done(20);

    // Abort after 5 words, then restart from the seed.
    launch(0, 16, 1'b0, '{lat: 0, ps: 1'b0, tmo: 1'b0, errs: '0}, 16);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp0.delete();
    exp1.delete();
    chk_all_zero("abort");
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    launch(0, 4, 1'b1, '{lat: 5, ps: 1'b1, tmo: 1'b0, errs: '0}, 4);
    @(negedge clk);
    chk("restart_word_ch0", 64'(lnk.tx_data[31:0]), 64'hACE1_0001);
    wait_done(30);

    chk("tx_queue_left", 64'(exp0.size() + exp1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_traffic_gen_chk.md
# stream_traffic_gen_chk

Synthesizable, parametrised stream traffic generator and checker used to exercise intercore links in hardware. It has `NUM_CHANNELS` independent valid/ready channels. On each channel it drives a pseudo-random burst out on `tx_*`, receives the looped-back stream on `rx_*`, and compares every received word against a locally regenerated copy of the same sequence. It sits beside the link under test and reports a run-level `done`/`pass` verdict, per-channel error counts and a timeout flag.

## Interface
- `DATA_WIDTH`, 32, word width, legal 8..32.
- `NUM_CHANNELS`, 1, independent channels, legal 1..8.
- `LEN_WIDTH`, 16, width of the burst length and of each error counter.
- `TIMEOUT_CYCLES`, 1024, RUN-state idle limit (no rx handshake on any channel), ≥2.
- `SEED`, 32'hACE1_0001, LFSR seed base; must be nonzero.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle run request.
- `burst_len`  in  LEN_WIDTH  words per channel; sampled on accepted `start`.
- `tx_valid`  out  NUM_CHANNELS  per-channel generator valid.
- `tx_data`  out  NUM_CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- `tx_ready`  in  NUM_CHANNELS  sink ready.
- `rx_valid`  in  NUM_CHANNELS  returned-stream valid.
- `rx_data`  in  NUM_CHANNELS*DATA_WIDTH  returned data, same packing as `tx_data`.
- `rx_ready`  out  NUM_CHANNELS  checker ready.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`.
- `timeout`  out  1  run ended by timeout.
- `err_count`  out  NUM_CHANNELS*LEN_WIDTH  per-channel mismatch count, saturating.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE or DONE, `start`=1: go to RUN. On this transition:
    - latch `burst_len`;
    - clear counters, `err_count` and `timeout`;
    - load both LFSRs of channel c with `SEED ^ c`.
  - `start` in RUN is ignored.
- **Data pattern:** 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, shifted left, feedback into bit 0.
  - Word = low `DATA_WIDTH` bits of the current state.
  - The first word is the seed itself.
  - The generator LFSR steps on each tx handshake; the checker LFSR steps on each rx handshake.
- **Generator, per channel:**
  - `tx_valid`=1 in RUN while tx_sent < burst_len.
  - Handshake = `tx_valid & tx_ready`.
  - `tx_data` is held stable while `tx_valid & !tx_ready`.
- **Checker, per channel:**
  - `rx_ready`=1 in RUN while rx_got < burst_len; 0 otherwise.
  - On each rx handshake, compare `rx_data` with the expected word. A mismatch increments `err_count`, saturating at all-ones.
- **RUN exits:**
  - → DONE when every channel has rx_got == burst_len.
  - → DONE with `timeout`=1 when `TIMEOUT_CYCLES` consecutive RUN cycles pass with no rx handshake on any channel.
- **`burst_len`=0:** RUN lasts exactly one cycle, then DONE with `pass`=1.
- **Verdict:** `pass` = DONE & !timeout & all `err_count` == 0.
- **Reset:** `rst` mid-run aborts to IDLE regardless of outstanding words.
- **Reset values:** every output 0, `tx_data` 0, counters 0.

## Timing
- `start` sampled at edge N: `busy`=1 and `tx_valid`=1 from cycle N+1. The first `tx_data` = `SEED ^ c` at N+1.
- Generator throughput: one word per cycle per channel when `tx_ready` is held high.
- Checker: `err_count` updates the cycle after the rx handshake. `done` rises the cycle after the last rx handshake, with `busy` falling the same cycle.
- Timeout counter:
  - resets on any rx handshake;
  - `done` and `timeout` assert on the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Counter widths:
  - tx/rx counters are `LEN_WIDTH` wide, no wrap: they stop at `burst_len`.
  - Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide.
- DONE holds until `start` or `rst`.
- Simultaneous last handshake and timeout expiry in the same cycle: completion wins, `timeout`=0.

## Structure
- **Package `traffic_pkg`:**
  - `state_t` enum (IDLE, RUN, DONE);
  - `LFSR_POLY` taps;
  - function `lfsr_next(logic [31:0])`.
- **Sub-module `traffic_channel`:** one per channel, holding generator LFSR, checker LFSR, tx/rx counters and `err_count`. It exports `chan_done`, `rx_hs` and `err_zero`.
- **Top:** owns the FSM, the timeout counter, `burst_len` latch and verdict logic, with a generate loop over `NUM_CHANNELS`.

## Test plan
- **Loopback:** `tx`→`rx` wired, `tx_ready`=1, `NUM_CHANNELS`=2, `burst_len`=16 → `done` at start+17 cycles, `pass`=1, `err_count`=0,0. First words 32'hACE1_0001 (ch0) and 32'hACE1_0000 (ch1).
- **Backpressure:** `tx_ready` toggles 1-0 with the loopback registered → `tx_data` stable during stalls, 16 words each, `pass`=1.
- **Corruption:** flip bit 0 of the 3rd and 7th rx words on ch1 → `err_count[ch1]`=2, `err_count[ch0]`=0, `pass`=0, `timeout`=0.
- **Timeout:** `TIMEOUT_CYCLES`=8, `rx_valid` held 0 → `done` and `timeout` at start+10, `pass`=0.
- **Zero length:** `burst_len`=0 → `tx_valid` never 1, `done` at start+2, `pass`=1.
- **Abort:** `rst` after 5 words, then a new `start` with `burst_len`=4 → all outputs 0 during reset. The sequence restarts from the seed and `pass`=1.
